// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU drive/return bus for alu_sequencer.
// slave = the sequencer; master = instruction source plus external ALU.
interface alu_sequencer_if #(
  parameter int unsigned n = 16
);
  logic [15:0]  instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [n-1:0] alu_x;
  logic [n-1:0] alu_y;
  logic         alu_cin;
  logic         alu_add_sub_control;
  logic [1:0]   alu_op;
  logic [n-1:0] alu_out;
  logic         alu_cout;
  logic         alu_z_flag;

  modport slave (
    input  instr, instr_valid, alu_out, alu_cout, alu_z_flag,
    output instr_ready, alu_x, alu_y, alu_cin, alu_add_sub_control, alu_op
  );

  modport master (
    output instr, instr_valid, alu_out, alu_cout, alu_z_flag,
    input  instr_ready, alu_x, alu_y, alu_cin, alu_add_sub_control, alu_op
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer driving an external ALU from an 8-entry register file.
// Define ALU_SEQ_ADDC_EN to enable opcode 110 (addc); otherwise 110 is illegal.
module alu_sequencer #(
  parameter int unsigned n = 16
) (
  input  logic          clock,
  input  logic          resetn,
  alu_sequencer_if.slave bus,
  output logic          done,
  output logic          illegal,
  output logic          z_flag,
  output logic          c_flag,
  input  logic [2:0]    dbg_sel,
  output logic [n-1:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_ADDC, OP_UNDEF
  } opcode_t;

  state_t       state, state_next;
  logic [15:0]  ir;
  logic [n-1:0] regs [8];
  logic [n-1:0] res_val;
  logic         res_c, res_z;

  opcode_t      opcode;
  logic [2:0]   rx, ry;
  logic         legal, x_zero, y_imm, dec_sub, dec_cin, wr_en, upd_z, upd_c;
  logic [1:0]   dec_op;
  logic         accept;

  assign opcode   = opcode_t'(ir[15:13]);
  assign rx       = ir[12:10];
  assign ry       = ir[9:7];
  assign accept   = bus.instr_valid && bus.instr_ready;
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    legal   = 1'b0;
    x_zero  = 1'b0;
    y_imm   = 1'b0;
    dec_sub = 1'b0;
    dec_cin = 1'b0;
    dec_op  = 2'b00;
    wr_en   = 1'b0;
    upd_z   = 1'b0;
    upd_c   = 1'b0;
    case (opcode)
      OP_MV:  begin legal = 1'b1; x_zero = 1'b1; wr_en = 1'b1; end
      OP_MVI: begin legal = 1'b1; x_zero = 1'b1; y_imm = 1'b1; wr_en = 1'b1; end
      OP_ADD: begin legal = 1'b1; wr_en = 1'b1; upd_z = 1'b1; upd_c = 1'b1; end
      OP_SUB: begin
        legal = 1'b1; dec_sub = 1'b1; dec_cin = 1'b1;
        wr_en = 1'b1; upd_z = 1'b1; upd_c = 1'b1;
      end
      OP_AND: begin legal = 1'b1; dec_op = 2'b01; wr_en = 1'b1; upd_z = 1'b1; end
      OP_CMP: begin
        legal = 1'b1; dec_sub = 1'b1; dec_cin = 1'b1; upd_z = 1'b1; upd_c = 1'b1;
      end
`ifdef ALU_SEQ_ADDC_EN
      OP_ADDC: begin
        legal = 1'b1; dec_cin = c_flag; wr_en = 1'b1; upd_z = 1'b1; upd_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // ALU drive is derived from IR in DECODE and EXECUTE only, so it is stable
  // across EXECUTE and sits at reset values otherwise (and for illegal opcodes).
  always_comb begin
    bus.instr_ready         = resetn && (state == IDLE);
    bus.alu_x               = '0;
    bus.alu_y               = '0;
    bus.alu_cin             = 1'b0;
    bus.alu_add_sub_control = 1'b0;
    bus.alu_op              = 2'b00;
    done                    = (state == WRITEBACK);
    illegal                 = (state == WRITEBACK) && !legal;
    if ((state == DECODE || state == EXECUTE) && legal) begin
      bus.alu_op              = dec_op;
      bus.alu_add_sub_control = dec_sub;
      bus.alu_cin             = dec_cin;
      if (!x_zero) bus.alu_x = regs[rx];
      if (y_imm) bus.alu_y[8:0] = ir[8:0];
      else       bus.alu_y      = regs[ry];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ir      <= '0;
      res_val <= '0;
      res_c   <= 1'b0;
      res_z   <= 1'b0;
      z_flag  <= 1'b0;
      c_flag  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (accept) ir <= bus.instr;
      if (state == EXECUTE) begin
        res_val <= bus.alu_out;
        res_c   <= bus.alu_cout;
        res_z   <= bus.alu_z_flag;
      end
      if (state == WRITEBACK) begin
        if (wr_en) regs[rx] <= res_val;
        if (upd_z) z_flag   <= res_z;
        if (upd_c) c_flag   <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes model results, a monitor
// pops them on done and sweeps the register file through dbg_sel every cycle.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        done, illegal, z_flag, c_flag;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  alu_sequencer_if #(.n(16)) bus ();

  alu_sequencer #(.n(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .done     (done),
    .illegal  (illegal),
    .z_flag   (z_flag),
    .c_flag   (c_flag),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // External ALU
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_x}
            + {1'b0, (bus.alu_add_sub_control ? ~bus.alu_y : bus.alu_y)}
            + 17'(bus.alu_cin);
    bus.alu_out  = '0;
    bus.alu_cout = 1'b0;
    if (bus.alu_op == 2'b00) begin
      bus.alu_out  = alu_sum[15:0];
      bus.alu_cout = alu_sum[16];
    end else if (bus.alu_op == 2'b01) begin
      bus.alu_out = bus.alu_x & bus.alu_y;
    end
    bus.alu_z_flag = (bus.alu_out == 16'h0000);
  end

  typedef struct {
    int unsigned cyc;
    bit          ill;
    bit          wr;
    bit [2:0]    rx;
    bit [15:0]   val;
    bit          z;
    bit          c;
  } exp_t;

  exp_t      sb[$];
  bit [15:0] m_regs [8];
  bit        m_z, m_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry);
    return {op, rx, ry, 7'd0};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] rx, input logic [8:0] imm);
    return {3'b001, rx, 1'b0, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] w, input int unsigned acc);
    logic [2:0]  op, rx, ry;
    logic [16:0] s;
    exp_t        e;
    op = w[15:13]; rx = w[12:10]; ry = w[9:7];
    e.cyc = acc + 2; e.ill = 1'b0; e.wr = 1'b0; e.rx = rx; e.val = '0;
    case (op)
      3'd0: begin e.wr = 1'b1; e.val = m_regs[ry]; end
      3'd1: begin e.wr = 1'b1; e.val = {7'd0, w[8:0]}; end
      3'd2: begin
        s = {1'b0, m_regs[rx]} + {1'b0, m_regs[ry]};
        e.wr = 1'b1; e.val = s[15:0]; m_z = (e.val == 0); m_c = s[16];
      end
      3'd3, 3'd5: begin
        e.val = m_regs[rx] - m_regs[ry];
        m_c = (m_regs[rx] >= m_regs[ry]); m_z = (e.val == 0); e.wr = (op == 3'd3);
      end
      3'd4: begin e.wr = 1'b1; e.val = m_regs[rx] & m_regs[ry]; m_z = (e.val == 0); end
`ifdef ALU_SEQ_ADDC_EN
      3'd6: begin
        s = {1'b0, m_regs[rx]} + {1'b0, m_regs[ry]} + 17'(m_c);
        e.wr = 1'b1; e.val = s[15:0]; m_z = (e.val == 0); m_c = s[16];
      end
`endif
      default: e.ill = 1'b1;
    endcase
    if (e.wr) m_regs[rx] = e.val;
    e.z = m_z;
    e.c = m_c;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] w);
    int t = 0;
    @(posedge clock); #1;
    bus.instr_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.instr_ready) begin
        bus.instr = w;
        break;
      end
      bus.instr = 16'($urandom);
      t++;
      if (t > 20) begin
        check("accept_timeout", bus.instr_ready, 1);
        bus.instr_valid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'($urandom);
    model_apply(w, cyc);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetn = 1'b0;
    bus.instr_valid = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clock);
      check("ready_in_reset", bus.instr_ready, 0);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clock);
    check("ready_after_reset", bus.instr_ready, 1);
    check("z_after_reset", z_flag, 0);
    check("c_after_reset", c_flag, 0);
  endtask

  // Monitor: retire-time checks, post-writeback flag checks, register sweep.
  initial begin
    bit          pend = 1'b0;
    exp_t        pe;
    bit [15:0]   shadow [8];
    int unsigned k = 0;
    dbg_sel = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        sb.delete();
        pend = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        continue;
      end
      if (pend) begin
        if (pe.wr) shadow[pe.rx] = pe.val;
        check("z_flag", z_flag, pe.z);
        check("c_flag", c_flag, pe.c);
        pend = 1'b0;
      end
      if (illegal) check("illegal_with_done", done, 1);
      if (done) begin
        check("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          pe = sb.pop_front();
          check("done_latency", cyc, pe.cyc);
          check("illegal", illegal, pe.ill);
          pend = 1'b1;
        end
      end
      dbg_sel = k[2:0];
      k++;
      #1;
      check("dbg_reg", {13'd0, dbg_sel, dbg_data}, {13'd0, dbg_sel, shadow[dbg_sel]});
    end
  end

  initial begin
    int t;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    do_reset();

    send(enc_i(3'd1, 9'h1FF));
    send(enc_i(3'd2, 9'h001));
    send(enc_r(3'b010, 3'd1, 3'd2));

    send(enc_i(3'd3, 9'd5));
    send(enc_r(3'b011, 3'd3, 3'd3));
    @(negedge clock);
    check("sub_alu_ctrl", {bus.alu_op, bus.alu_add_sub_control, bus.alu_cin}, 4'b0011);
    send(enc_i(3'd4, 9'd1));
    send(enc_r(3'b101, 3'd4, 3'd3));

    send(enc_i(3'd5, 9'd0));
    send(enc_i(3'd7, 9'd1));
    send(enc_r(3'b011, 3'd5, 3'd7));
    send(enc_i(3'd6, 9'd1));
    send(enc_r(3'b010, 3'd5, 3'd6));
`ifdef ALU_SEQ_ADDC_EN
    send(enc_r(3'b110, 3'd6, 3'd6));
`endif

    send(16'hE000);
    repeat (2) begin
      @(negedge clock);
      check("illegal_alu_idle", {|bus.alu_x, |bus.alu_y, bus.alu_cin,
                                 bus.alu_add_sub_control, bus.alu_op}, 0);
    end
    send(enc_r(3'b110, 3'd1, 3'd2));
    send(enc_r(3'b100, 3'd5, 3'd6));

    // Reset while add r1,r2 is in EXECUTE: no retirement, R1 remains 0.
    do_reset();
    send(enc_i(3'd2, 9'd7));
    send(enc_r(3'b010, 3'd1, 3'd2));
    @(posedge clock); #1;
    resetn = 1'b0;
    model_reset();
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("ready_after_mid_reset", bus.instr_ready, 1);

    repeat (60) send(16'($urandom));

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("drain", sb.size(), 0);
    repeat (10) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
